// File: rtl/lock_pkg.sv
// Shared types and helpers for the serial-entry digital lock.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlocked and lockout phases.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (tick && cnt != '0)
            cnt <= cnt - W'(1);
    end

    // High in the final cycle of a loaded interval, so the phase ends on this edge.
    assign done = (cnt <= W'(1));

endmodule

// File: rtl/param_digital_lock.sv
// Serial-entry digital lock with prefix hint, fail counting, lockout and auto-relock.
module param_digital_lock
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    parameter int                  UNLOCK_CYCLES  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            x_valid,
    input  logic                            x,
    input  logic                            lock_req,
    output logic                            unlocked,
    output logic                            closer,
    output logic                            locked_out,
    output logic [clog2(MAX_FAILS+1)-1:0]   fail_cnt,
    output logic [clog2(CODE_LEN+1)-1:0]    progress
);

    localparam int FW   = clog2(MAX_FAILS + 1);
    localparam int PW   = clog2(CODE_LEN + 1);
    localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
                          LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW   = clog2(TMAX + 1);

    if (CODE_LEN < 1 || CODE_LEN > 16 || MAX_FAILS < 1 ||
        LOCKOUT_CYCLES < 1 || UNLOCK_CYCLES < 0) begin : g_bad_params
        $error("param_digital_lock: illegal parameter set");
    end

    state_t              state;
    logic [CODE_LEN-1:0] shreg;
    logic [CODE_LEN-1:0] shifted;
    logic                last;
    logic                match;
    logic                fail_last;
    logic                accept;
    logic                t_load;
    logic                t_tick;
    logic                t_done;
    logic [TW-1:0]       t_val;

    assign shifted   = (shreg << 1) | CODE_LEN'(x);
    assign last      = (progress == PW'(CODE_LEN - 1));
    assign match     = (shifted == CODE);
    assign fail_last = (int'(fail_cnt) + 1 >= MAX_FAILS);
    assign accept    = (state == ST_COLLECT) && x_valid && !lock_req && last;

    assign t_load = accept && (match || fail_last);
    assign t_val  = match ? TW'(UNLOCK_CYCLES) : TW'(LOCKOUT_CYCLES);
    assign t_tick = (state != ST_COLLECT);

    lock_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .tick     (t_tick),
        .done     (t_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_COLLECT;
            shreg    <= '0;
            progress <= '0;
            fail_cnt <= '0;
        end else begin
            unique case (state)
                ST_COLLECT: begin
                    if (lock_req) begin
                        shreg    <= '0;
                        progress <= '0;
                    end else if (x_valid) begin
                        shreg <= shifted;
                        if (last) begin
                            progress <= '0;
                            if (match) begin
                                state    <= ST_UNLOCKED;
                                fail_cnt <= '0;
                            end else if (fail_last) begin
                                state    <= ST_LOCKOUT;
                                fail_cnt <= FW'(MAX_FAILS);
                            end else begin
                                fail_cnt <= fail_cnt + FW'(1);
                            end
                        end else begin
                            progress <= progress + PW'(1);
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (lock_req || (UNLOCK_CYCLES != 0 && t_done))
                        state <= ST_COLLECT;
                end
                ST_LOCKOUT: begin
                    if (t_done) begin
                        state    <= ST_COLLECT;
                        fail_cnt <= '0;
                        progress <= '0;
                        shreg    <= '0;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    assign unlocked   = (state == ST_UNLOCKED);
    assign locked_out = (state == ST_LOCKOUT);

    // With a one-bit code there is no prefix to hint at.
    if (CODE_LEN == 1) begin : g_closer_none
        assign closer = 1'b0;
    end else begin : g_closer
        assign closer = (state == ST_COLLECT) && last &&
                        (shreg[CODE_LEN-2:0] == CODE[CODE_LEN-1:1]);
    end

endmodule

// File: tb/tb_param_digital_lock.sv
// Directed bench: default lock plus a 6-bit no-auto-relock variant, scoreboard-checked.
module tb_param_digital_lock;

    logic       clk = 1'b0;
    logic       rst;
    logic       xv, xb, lr;
    logic       xv6, xb6, lr6;
    logic       ul, cl, lo;
    logic [1:0] fc;
    logic [2:0] pg;
    logic       ul6, cl6, lo6;
    logic [1:0] fc6;
    logic [2:0] pg6;

    typedef struct {
        string      name;
        int         due;
        bit         six;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_digital_lock u_dut (
        .clk        (clk),
        .rst        (rst),
        .x_valid    (xv),
        .x          (xb),
        .lock_req   (lr),
        .unlocked   (ul),
        .closer     (cl),
        .locked_out (lo),
        .fail_cnt   (fc),
        .progress   (pg)
    );

    param_digital_lock #(
        .CODE_LEN      (6),
        .CODE          (6'b110010),
        .UNLOCK_CYCLES (0)
    ) u_dut6 (
        .clk        (clk),
        .rst        (rst),
        .x_valid    (xv6),
        .x          (xb6),
        .lock_req   (lr6),
        .unlocked   (ul6),
        .closer     (cl6),
        .locked_out (lo6),
        .fail_cnt   (fc6),
        .progress   (pg6)
    );

    // Monitor: compares every expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            got = e.six ? {ul6, cl6, lo6, fc6, pg6} : {ul, cl, lo, fc, pg};
            vectors++;
            if (got !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got ul,cl,lo,fc,pg=%b,%b,%b,%0d,%0d required %b,%b,%b,%0d,%0d",
                         e.name, got[7], got[6], got[5], got[4:3], got[2:0],
                         e.exp[7], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
            end
        end
    end

    function automatic logic [7:0] pk(input bit u, input bit c, input bit l,
                                      input int f, input int p);
        return {u, c, l, 2'(f), 3'(p)};
    endfunction

    task automatic chk(input string n, input bit six, input logic [7:0] ex);
        sb.push_back('{n, cyc, six, ex});
    endtask

    task automatic stepa(input bit v, input bit b, input bit l);
        xv = v; xb = b; lr = l;
        @(posedge clk); #1;
        xv = 1'b0; xb = 1'b0; lr = 1'b0;
    endtask

    task automatic stepb(input bit v, input bit b, input bit l);
        xv6 = v; xb6 = b; lr6 = l;
        @(posedge clk); #1;
        xv6 = 1'b0; xb6 = 1'b0; lr6 = 1'b0;
    endtask

    task automatic idle();
        stepa(1'b0, 1'b0, 1'b0);
    endtask

    task automatic feed(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) stepa(1'b1, c[i], 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        xv = 0; xb = 0; lr = 0;
        xv6 = 0; xb6 = 0; lr6 = 0;
        idle();
        chk("reset_a", 0, pk(0, 0, 0, 0, 0));
        chk("reset_b", 1, pk(0, 0, 0, 0, 0));
        rst = 1'b0;

        // Correct code, closer hint, auto-relock after 8 cycles.
        stepa(1, 1, 0);
        chk("t1_prog1", 0, pk(0, 0, 0, 0, 1));
        stepa(1, 0, 0);
        stepa(1, 1, 0);
        chk("t1_closer", 0, pk(0, 1, 0, 0, 3));
        stepa(1, 1, 0);
        chk("t1_unlock", 0, pk(1, 0, 0, 0, 0));
        repeat (7) idle();
        chk("t1_hold8", 0, pk(1, 0, 0, 0, 0));
        idle();
        chk("t1_autorelock", 0, pk(0, 0, 0, 0, 0));

        // One failure then success, then explicit relock.
        feed(4'b1010);
        chk("t2_fail1", 0, pk(0, 0, 0, 1, 0));
        feed(4'b1011);
        chk("t2_unlock", 0, pk(1, 0, 0, 0, 0));
        stepa(0, 0, 1);
        chk("t2_lockreq", 0, pk(0, 0, 0, 0, 0));

        // Three failures, lockout for 16 cycles, input ignored meanwhile.
        feed(4'b0000);
        chk("t3_fail1", 0, pk(0, 0, 0, 1, 0));
        feed(4'b0000);
        chk("t3_fail2", 0, pk(0, 0, 0, 2, 0));
        feed(4'b0000);
        chk("t3_lockout", 0, pk(0, 0, 1, 3, 0));
        feed(4'b1011);
        chk("t3_ignored", 0, pk(0, 0, 1, 3, 0));
        repeat (11) idle();
        chk("t3_lo16", 0, pk(0, 0, 1, 3, 0));
        idle();
        chk("t3_expire", 0, pk(0, 0, 0, 0, 0));
        feed(4'b1011);
        chk("t3_unlock", 0, pk(1, 0, 0, 0, 0));
        stepa(0, 0, 1);
        chk("t3_relock", 0, pk(0, 0, 0, 0, 0));

        // Abort mid-attempt keeps fail count; lock_req beats x_valid.
        stepa(1, 1, 0);
        stepa(1, 1, 0);
        stepa(1, 1, 0);
        chk("t4_nocloser", 0, pk(0, 0, 0, 0, 3));
        stepa(1, 1, 0);
        chk("t4_fail", 0, pk(0, 0, 0, 1, 0));
        stepa(1, 1, 0);
        stepa(1, 0, 0);
        chk("t4_prog2", 0, pk(0, 0, 0, 1, 2));
        stepa(0, 0, 1);
        chk("t4_abort", 0, pk(0, 0, 0, 1, 0));
        feed(4'b1011);
        chk("t4_unlock", 0, pk(1, 0, 0, 0, 0));
        stepa(0, 0, 1);
        chk("t4_relock", 0, pk(0, 0, 0, 0, 0));
        stepa(1, 1, 1);
        chk("t4_discard", 0, pk(0, 0, 0, 0, 0));
        feed(4'b1011);
        chk("t4_unlock2", 0, pk(1, 0, 0, 0, 0));
        stepa(0, 0, 1);

        // Reset in the middle of lockout and of unlock.
        feed(4'b0000);
        feed(4'b0000);
        feed(4'b0000);
        idle();
        idle();
        chk("t5_inlockout", 0, pk(0, 0, 1, 3, 0));
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("t5_rst_lockout", 0, pk(0, 0, 0, 0, 0));
        feed(4'b1011);
        idle();
        idle();
        chk("t5_inunlock", 0, pk(1, 0, 0, 0, 0));
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("t5_rst_unlock", 0, pk(0, 0, 0, 0, 0));

        // 6-bit code 110010 with gaps, no auto-relock.
        stepb(1, 1, 0);
        stepb(0, 0, 0);
        stepb(1, 1, 0);
        stepb(1, 0, 0);
        stepb(0, 0, 0);
        stepb(0, 0, 0);
        stepb(1, 0, 0);
        stepb(1, 1, 0);
        chk("t6_closer", 1, pk(0, 1, 0, 0, 5));
        stepb(0, 0, 0);
        chk("t6_gap", 1, pk(0, 1, 0, 0, 5));
        stepb(1, 0, 0);
        chk("t6_unlock", 1, pk(1, 0, 0, 0, 0));
        repeat (20) stepb(0, 0, 0);
        chk("t6_stay", 1, pk(1, 0, 0, 0, 0));
        stepb(0, 0, 1);
        chk("t6_lockreq", 1, pk(0, 0, 0, 0, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
